// File: rtl/bus_crossbar_pkg.sv
// Shared constants and types for the bus crossbar.
//   ADDRESS_WIDTH / DATA_WIDTH / BANK_WIDTH : bus field widths
//   BANK_*                                  : bank codes used to route transactions
//   dev_state_e                             : per-device transaction state
//   idx_w()                                 : index width that stays >= 1 for single-entry sets
package bus_crossbar_pkg;
  localparam int ADDRESS_WIDTH = 26;
  localparam int DATA_WIDTH    = 32;
  localparam int BANK_WIDTH    = 4;

  localparam logic [BANK_WIDTH-1:0] BANK_SDRAM    = 4'h1;
  localparam logic [BANK_WIDTH-1:0] BANK_CART     = 4'h2;
  localparam logic [BANK_WIDTH-1:0] BANK_EEPROM   = 4'h3;
  localparam logic [BANK_WIDTH-1:0] BANK_FLASHRAM = 4'h4;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } dev_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bus_crossbar_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr_i, wrapping modulo N.
//   req_i : request vector        ptr_i : highest-priority index this cycle
//   gnt_o : one-hot grant         idx_o : grant index    vld_o : any request present
module bus_crossbar_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);
  int k;

  // Walk offsets from farthest to nearest so the nearest requester overwrites.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    k     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = int'(ptr_i) + i;
      if (k >= N) k = k - N;
      if (req_i[k]) begin
        gnt_o    = '0;
        gnt_o[k] = 1'b1;
        idx_o    = IW'(k);
        vld_o    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bus_crossbar.sv
// N-controller x M-device interconnect. Each controller request is decoded by bank
// code to one device (lowest matching device wins), arbitrated round-robin per
// device, forwarded, and the device ack/data is routed back to the owning controller
// one cycle later. Unmapped banks complete immediately with data 0.
// Ports:
//   i_clk, i_reset                : clock, synchronous active-high reset
//   i_request/i_write/i_bank/
//   i_address/i_data              : per-controller transaction (held until accepted)
//   o_busy                        : combinational stall (0 = accepted this cycle)
//   o_ack/o_data                  : registered completion pulse and read data
//   o_device_*                    : forwarded transaction per device
//   i_device_busy/ack/data        : device stall, completion pulse, read data
//   o_timeout                     : one-cycle watchdog expiry pulse per device
// Optional: define BUS_CROSSBAR_TIMEOUT_EN to build the per-device ack watchdog
// (expiry after TIMEOUT_CYCLES waiting cycles, returns 32'hFFFF_FFFF).
module bus_crossbar
  import bus_crossbar_pkg::*;
#(
  parameter int NUM_CONTROLLERS = 2,
  parameter int NUM_DEVICES     = 4,
  parameter logic [NUM_DEVICES-1:0][BANK_WIDTH-1:0] DEVICE_BANKS =
    {BANK_FLASHRAM, BANK_EEPROM, BANK_CART, BANK_SDRAM},
  parameter int TIMEOUT_CYCLES  = 1023
) (
  input  logic                                            i_clk,
  input  logic                                            i_reset,
  input  logic [NUM_CONTROLLERS-1:0]                      i_request,
  input  logic [NUM_CONTROLLERS-1:0]                      i_write,
  output logic [NUM_CONTROLLERS-1:0]                      o_busy,
  output logic [NUM_CONTROLLERS-1:0]                      o_ack,
  input  logic [NUM_CONTROLLERS-1:0][BANK_WIDTH-1:0]      i_bank,
  input  logic [NUM_CONTROLLERS-1:0][ADDRESS_WIDTH-1:0]   i_address,
  input  logic [NUM_CONTROLLERS-1:0][DATA_WIDTH-1:0]      i_data,
  output logic [NUM_CONTROLLERS-1:0][DATA_WIDTH-1:0]      o_data,
  output logic [NUM_DEVICES-1:0]                          o_device_request,
  output logic [NUM_DEVICES-1:0]                          o_device_write,
  input  logic [NUM_DEVICES-1:0]                          i_device_busy,
  input  logic [NUM_DEVICES-1:0]                          i_device_ack,
  output logic [NUM_DEVICES-1:0][ADDRESS_WIDTH-1:0]       o_device_address,
  output logic [NUM_DEVICES-1:0][DATA_WIDTH-1:0]          o_device_data,
  input  logic [NUM_DEVICES-1:0][DATA_WIDTH-1:0]          i_device_data,
  output logic [NUM_DEVICES-1:0]                          o_timeout
);
  localparam int N  = NUM_CONTROLLERS;
  localparam int M  = NUM_DEVICES;
  localparam int IW = idx_w(N);

  logic [N-1:0][M-1:0]          hit;        // one-hot decoded target per controller
  logic [N-1:0]                 mapped, accept, ack_d, ack_q, pending_d, pending_q;
  logic [N-1:0][DATA_WIDTH-1:0] data_d, data_q;
  logic [M-1:0][N-1:0]          dreq, dgnt;
  logic [M-1:0][IW-1:0]         widx, owner_v;
  logic [M-1:0]                 wvld, fwd, resp, tmo;
  logic [M-1:0][DATA_WIDTH-1:0] rdata;

  // Descending scan so the lowest matching device is the final write.
  always_comb begin
    hit    = '0;
    mapped = '0;
    for (int c = 0; c < N; c++)
      for (int d = M - 1; d >= 0; d--)
        if (i_bank[c] == DEVICE_BANKS[d]) begin
          hit[c]    = '0;
          hit[c][d] = 1'b1;
          mapped[c] = 1'b1;
        end
  end

  for (genvar d = 0; d < M; d++) begin : g_dev
    dev_state_e    state_q;
    logic [IW-1:0] ptr_q, owner_q;

    // A controller with a transaction in flight never competes again.
    for (genvar c = 0; c < N; c++) begin : g_req
      assign dreq[d][c] = i_request[c] & hit[c][d] & ~pending_q[c];
    end

    bus_crossbar_rr_arbiter #(.N(N), .IW(IW)) u_arb (
      .req_i (dreq[d]),
      .ptr_i (ptr_q),
      .gnt_o (dgnt[d]),
      .idx_o (widx[d]),
      .vld_o (wvld[d])
    );

    assign fwd[d]              = (state_q == ST_IDLE) & wvld[d] & ~i_device_busy[d];
    assign o_device_request[d] = fwd[d];
    assign o_device_write[d]   = i_write[widx[d]];
    assign o_device_address[d] = i_address[widx[d]];
    assign o_device_data[d]    = i_data[widx[d]];

`ifdef BUS_CROSSBAR_TIMEOUT_EN
    localparam int CW = idx_w(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt_q;
    // A real ack in the expiry cycle wins over the watchdog.
    assign tmo[d] = (state_q == ST_WAIT_ACK) & ~i_device_ack[d] &
                    (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge i_clk) begin
      if (i_reset || fwd[d])              cnt_q <= '0;
      else if (state_q == ST_WAIT_ACK)    cnt_q <= cnt_q + 1'b1;
    end
`else
    assign tmo[d] = 1'b0;
`endif

    // Acks seen outside WAIT_ACK (e.g. after reset or expiry) are dropped here.
    assign resp[d]    = (state_q == ST_WAIT_ACK) & (i_device_ack[d] | tmo[d]);
    assign rdata[d]   = i_device_ack[d] ? i_device_data[d] : '1;
    assign owner_v[d] = owner_q;

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        state_q <= ST_IDLE;
        ptr_q   <= '0;
        owner_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: if (fwd[d]) begin
            owner_q <= widx[d];
            ptr_q   <= (widx[d] == IW'(N - 1)) ? '0 : widx[d] + 1'b1;
            state_q <= ST_WAIT_ACK;
          end
          ST_WAIT_ACK: if (resp[d]) state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Response OR-mux: at most one device can own a given controller at a time.
  for (genvar c = 0; c < N; c++) begin : g_ctl
    logic                  unm, acc_l, ack_l;
    logic [DATA_WIDTH-1:0] dat_l;
    always_comb begin
      unm   = i_request[c] & ~mapped[c] & ~pending_q[c];
      acc_l = unm;
      ack_l = unm;
      dat_l = '0;
      for (int d = 0; d < M; d++) begin
        if (fwd[d] && dgnt[d][c]) acc_l = 1'b1;
        if (resp[d] && owner_v[d] == IW'(c)) begin
          ack_l = 1'b1;
          dat_l = dat_l | rdata[d];
        end
      end
    end
    assign accept[c] = acc_l;
    assign ack_d[c]  = ack_l;
    assign data_d[c] = dat_l;
  end

  assign pending_d = (pending_q & ~ack_d) | (accept & mapped);
  assign o_busy    = ~accept;
  assign o_ack     = ack_q;
  assign o_data    = data_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ack_q     <= '0;
      data_q    <= '0;
      pending_q <= '0;
    end else begin
      ack_q     <= ack_d;
      data_q    <= data_d;
      pending_q <= pending_d;
    end
  end

`ifdef BUS_CROSSBAR_TIMEOUT_EN
  logic [M-1:0] timeout_q;
  always_ff @(posedge i_clk) begin
    if (i_reset) timeout_q <= '0;
    else         timeout_q <= tmo;
  end
  assign o_timeout = timeout_q;
`else
  assign o_timeout = '0;
`endif
endmodule

// File: tb/tb_bus_crossbar.sv
// Bench for bus_crossbar: N=2 controllers, M=3 devices (banks 1,5,5 so device 2
// is shadowed by device 1). A transaction-level model predicts accepts, forwards
// and acks every cycle; table vectors and directed sequences cover the corners.
module tb_bus_crossbar;
  localparam int N = 2, M = 3, TO = 16;

  logic clk = 1'b0, rst;
  logic [N-1:0] req, wr, busy, ack;
  logic [N-1:0][3:0]  bank;
  logic [N-1:0][25:0] addr;
  logic [N-1:0][31:0] wdata, rdata;
  logic [M-1:0] dreq, dwr, dbusy, dack, dtmo;
  logic [M-1:0][25:0] daddr;
  logic [M-1:0][31:0] dwdata, ddata;

  always #5 clk = ~clk;

  bus_crossbar #(.NUM_CONTROLLERS(N), .NUM_DEVICES(M),
                 .DEVICE_BANKS({4'h5, 4'h5, 4'h1}), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_reset(rst), .i_request(req), .i_write(wr), .o_busy(busy),
    .o_ack(ack), .i_bank(bank), .i_address(addr), .i_data(wdata), .o_data(rdata),
    .o_device_request(dreq), .o_device_write(dwr), .i_device_busy(dbusy),
    .i_device_ack(dack), .o_device_address(daddr), .o_device_data(dwdata),
    .i_device_data(ddata), .o_timeout(dtmo));

  int checks = 0, failures = 0, nacc = 0;
  logic [3:0] BK [M] = '{4'h1, 4'h5, 4'h5};

  // Transaction-level model state
  int owner [M], last [M], age [M], dly [M];
  bit [N-1:0] outst, acc_q, exp_ack;
  logic [N-1:0][31:0] exp_data;
  bit [M-1:0] exp_tmo;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int target(input logic [3:0] b);
    for (int d = 0; d < M; d++) if (b == BK[d]) return d;
    return -1;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < M; d++) begin owner[d] = -1; last[d] = N - 1; age[d] = 0; dly[d] = -1; end
    outst = '0; acc_q = '0; exp_ack = '0; exp_data = '0; exp_tmo = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
  endtask

  // Check the current cycle against the model, then advance model and clock.
  task automatic step();
    bit [N-1:0] acc, nxt_ack, exp_busy;
    bit [M-1:0] fwd, nxt_tmo;
    logic [N-1:0][31:0] nxt_data;
    int win [M];
    @(negedge clk);
    acc = '0; fwd = '0; nxt_ack = '0; nxt_tmo = '0; nxt_data = '0;
    for (int d = 0; d < M; d++) begin
      win[d] = -1;
      if (owner[d] < 0 && !dbusy[d])
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (last[d] + k) % N;
          if (win[d] < 0 && req[c] && !outst[c] && target(bank[c]) == d) win[d] = c;
        end
      if (win[d] >= 0) begin fwd[d] = 1'b1; acc[win[d]] = 1'b1; end
    end
    for (int c = 0; c < N; c++)
      if (req[c] && !outst[c] && target(bank[c]) < 0) begin acc[c] = 1'b1; nxt_ack[c] = 1'b1; end
    exp_busy = ~acc;
    chk("busy", busy, exp_busy);
    chk("dev_req", dreq, fwd);
    for (int d = 0; d < M; d++)
      if (fwd[d]) begin
        chk("dev_addr", daddr[d], addr[win[d]]);
        chk("dev_wdata", dwdata[d], wdata[win[d]]);
        chk("dev_write", dwr[d], wr[win[d]]);
      end
    chk("ack", ack, exp_ack);
    for (int c = 0; c < N; c++) if (exp_ack[c]) chk("ack_data", rdata[c], exp_data[c]);
    chk("timeout", dtmo, exp_tmo);
    for (int d = 0; d < M; d++)
      if (owner[d] >= 0) begin
        if (dack[d]) begin
          nxt_ack[owner[d]] = 1'b1; nxt_data[owner[d]] = ddata[d];
          outst[owner[d]] = 1'b0; owner[d] = -1;
        end
`ifdef BUS_CROSSBAR_TIMEOUT_EN
        else if (age[d] == TO - 1) begin
          nxt_ack[owner[d]] = 1'b1; nxt_data[owner[d]] = 32'hFFFF_FFFF; nxt_tmo[d] = 1'b1;
          outst[owner[d]] = 1'b0; owner[d] = -1;
        end else age[d]++;
`endif
      end
    for (int d = 0; d < M; d++)
      if (fwd[d]) begin owner[d] = win[d]; last[d] = win[d]; outst[win[d]] = 1'b1; age[d] = 0; end
    acc_q = acc; exp_ack = nxt_ack; exp_data = nxt_data; exp_tmo = nxt_tmo;
    @(posedge clk); #1;
  endtask

  task automatic drv_rand();
    for (int c = 0; c < N; c++) begin
      if (acc_q[c]) req[c] = 1'b0;
      if (!req[c] && $urandom_range(0, 2) == 0) begin
        req[c] = 1'b1;
        case ($urandom_range(0, 3))
          0: bank[c] = 4'h1;
          1: bank[c] = 4'h5;
          2: bank[c] = 4'hF;
          default: bank[c] = 4'($urandom_range(0, 15));
        endcase
        wr[c] = 1'($urandom); addr[c] = 26'($urandom); wdata[c] = $urandom;
      end
    end
    for (int d = 0; d < M; d++) begin
      dack[d] = 1'b0; ddata[d] = $urandom; dbusy[d] = ($urandom_range(0, 3) == 0);
      if (owner[d] >= 0) begin
        if (dly[d] < 0) dly[d] = $urandom_range(0, 3);
        if (dly[d] == 0) begin dack[d] = 1'b1; dly[d] = -1; end
        else dly[d]--;
      end
    end
  endtask

  typedef struct {
    logic [1:0] req; logic [3:0] b0, b1; logic [2:0] db;
    logic [1:0] eb;  logic [2:0] ed;
  } vec_t;
  vec_t tbl [10];
  int got [$];
  int rr_exp [4] = '{0, 1, 0, 1};

  initial begin
    rst = 1'b1; req = '0; wr = '0; bank = '0; addr = '0; wdata = '0;
    dbusy = '0; dack = '0; ddata = '0;
    clear_model();
    do_reset(); do_reset();
    chk("rst_ack", ack, 0); chk("rst_data", rdata, 0); chk("rst_tmo", dtmo, 0);
    step();

    // {req, bank0, bank1, dev busy, expected busy, expected device request}
    tbl[0] = '{2'b00, 4'h1, 4'h1, 3'b000, 2'b11, 3'b000};
    tbl[1] = '{2'b01, 4'h1, 4'h1, 3'b000, 2'b10, 3'b001};
    tbl[2] = '{2'b10, 4'h1, 4'h5, 3'b000, 2'b01, 3'b010};
    tbl[3] = '{2'b11, 4'h5, 4'h5, 3'b000, 2'b10, 3'b010};
    tbl[4] = '{2'b11, 4'h1, 4'h5, 3'b000, 2'b00, 3'b011};
    tbl[5] = '{2'b01, 4'h1, 4'h1, 3'b001, 2'b11, 3'b000};
    tbl[6] = '{2'b10, 4'h1, 4'hF, 3'b000, 2'b01, 3'b000};
    tbl[7] = '{2'b11, 4'hF, 4'h1, 3'b001, 2'b10, 3'b000};
    tbl[8] = '{2'b11, 4'h5, 4'h5, 3'b010, 2'b11, 3'b000};
    tbl[9] = '{2'b01, 4'h0, 4'h1, 3'b000, 2'b10, 3'b000};
    foreach (tbl[i]) begin
      do_reset();
      req = tbl[i].req; bank[0] = tbl[i].b0; bank[1] = tbl[i].b1; dbusy = tbl[i].db; dack = '0;
      #1;
      chk("tbl_busy", busy, tbl[i].eb);
      chk("tbl_dreq", dreq, tbl[i].ed);
      step();
    end
    req = '0; dbusy = '0;

    // Single read, ack three cycles after forward
    do_reset();
    req = 2'b01; bank[0] = 4'h1; wr[0] = 1'b0; addr[0] = 26'h0ABCDE;
    #1 chk("t1_addr", daddr[0], 26'h0ABCDE);
    step();
    req = '0; step(); step();
    dack[0] = 1'b1; ddata[0] = 32'h1234_5678;
    #1 chk("t1_noack", ack, 0);
    step();
    dack = '0;
    #1 chk("t1_ack", ack, 2'b01); chk("t1_data", rdata[0], 32'h1234_5678);
    step();
    #1 chk("t1_pulse", ack, 0);
    step();

    // Contention on one device: grants alternate
    do_reset();
    req = 2'b11; bank[0] = 4'h5; bank[1] = 4'h5; got.delete();
    for (int i = 0; i < 12; i++) begin
      for (int d = 0; d < M; d++) begin dack[d] = (owner[d] >= 0); ddata[d] = $urandom; end
      #1 for (int c = 0; c < N; c++) if (!busy[c]) got.push_back(c);
      step();
    end
    req = '0; dack = '0;
    chk("rr_count", got.size() >= 4, 1);
    for (int i = 0; i < 4; i++) if (i < got.size()) chk("rr_order", got[i], rr_exp[i]);
    step(); step();

    // Two devices complete in the same cycle
    do_reset();
    req = 2'b11; bank[0] = 4'h1; bank[1] = 4'h5;
    #1 chk("par_dreq", dreq, 3'b011);
    step();
    req = '0; step();
    dack = 3'b011; ddata[0] = 32'hA5A5_0001; ddata[1] = 32'h5A5A_0002;
    step();
    dack = '0;
    #1 chk("par_ack", ack, 2'b11);
    chk("par_d0", rdata[0], 32'hA5A5_0001); chk("par_d1", rdata[1], 32'h5A5A_0002);
    step();

    // Unmapped bank
    do_reset();
    req = 2'b10; bank[1] = 4'hF;
    #1 chk("unm_busy", busy[1], 0); chk("unm_dreq", dreq, 0);
    step();
    req = '0;
    #1 chk("unm_ack", ack, 2'b10); chk("unm_data", rdata[1], 0);
    step();

    // Device busy for five cycles
    do_reset();
    dbusy = 3'b001; req = 2'b01; bank[0] = 4'h1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bsy_dreq", dreq[0], 0); chk("bsy_busy", busy[0], 1);
      step();
    end
    dbusy = '0;
    #1 chk("bsy_fwd", dreq[0], 1); chk("bsy_acc", busy[0], 0);
    step();
    req = '0; dack[0] = 1'b1; ddata[0] = 32'h0000_BEEF;
    step();
    dack = '0; step();

    // Reset while waiting, then a late ack must be ignored
    do_reset();
    req = 2'b01; bank[0] = 4'h1;
    step();
    req = '0; step();
    do_reset();
    dack[0] = 1'b1; ddata[0] = 32'hDEAD_BEEF;
    step();
    dack = '0;
    #1 chk("late_ack", ack, 0); chk("late_data", rdata, 0);
    step();

`ifdef BUS_CROSSBAR_TIMEOUT_EN
    do_reset();
    req = 2'b01; bank[0] = 4'h1;
    step();
    req = '0;
    for (int i = 0; i < TO; i++) begin
      #1 chk("to_early", dtmo, 0);
      step();
    end
    #1 chk("to_pulse", dtmo, 3'b001); chk("to_ack", ack, 2'b01);
    chk("to_data", rdata[0], 32'hFFFF_FFFF);
    step();
    dack[0] = 1'b1; ddata[0] = 32'h1111_2222;
    step();
    dack = '0;
    #1 chk("to_late", ack, 0);
    step();
    req = 2'b01;
    step();
    req = '0; step(); step();
    do_reset();
    #1 chk("to_rst_ack", ack, 0); chk("to_rst_tmo", dtmo, 0); chk("to_rst_data", rdata, 0);
    step();
`endif

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drv_rand();
      step();
      nacc += $countones(acc_q);
    end
    req = '0; dack = '0;
    chk("rand_progress", nacc >= 100, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
